// File: rtl/jt12_ch_wr_ctl.sv
// CPU write front-end for the YM2612 channel register file: edge-detects bus writes,
// holds one pending data write, commits it on cen with a decoded update strobe.
module jt12_ch_wr_ctl #(
  parameter int NUM_CH   = 6,
  parameter int BUSY_CYC = 32
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic [7:0] cpu_din,
  input  logic [1:0] addr,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic       busy,
  output logic [7:0] din,
  output logic [2:0] up_ch,
  output logic [5:0] latch_fnum,
  output logic       up_fnumlo,
  output logic       up_alg,
  output logic       up_pms,
  output logic [2:0] ch
);

  localparam int CW = $clog2(BUSY_CYC + 1);

  logic [CW-1:0] cnt;
  logic          last_wr;
  logic [7:0]    selreg;
  logic          part;
  logic          pend;
  logic [7:0]    pend_sel;
  logic          pend_part;
  logic [7:0]    pend_data;

  logic wr_act, wr_ev, addr_wr, data_wr, commit, low_ok;
  logic [2:0] commit_ch;

  assign wr_act  = !cs_n && !wr_n;
  assign wr_ev   = wr_act && !last_wr;
  assign addr_wr = wr_ev && !addr[0];
  assign data_wr = wr_ev &&  addr[0];
  assign commit  = cen && pend;
  assign low_ok  = pend_sel[1:0] != 2'd3;
  assign commit_ch = pend_part ? 3'd3 + {1'b0, pend_sel[1:0]} : {1'b0, pend_sel[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      // history starts "active" so a strobe held across reset release is not a write
      last_wr    <= 1'b1;
      selreg     <= '0;
      part       <= 1'b0;
      pend       <= 1'b0;
      pend_sel   <= '0;
      pend_part  <= 1'b0;
      pend_data  <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      din        <= '0;
      up_ch      <= '0;
      latch_fnum <= '0;
      up_fnumlo  <= 1'b0;
      up_alg     <= 1'b0;
      up_pms     <= 1'b0;
      ch         <= '0;
    end else begin
      last_wr   <= wr_act;
      up_fnumlo <= 1'b0;
      up_alg    <= 1'b0;
      up_pms    <= 1'b0;

      if (addr_wr) begin
        selreg <= cpu_din;
        part   <= (NUM_CH > 3) ? addr[1] : 1'b0;
      end

      // a new data write in the commit cycle re-arms pending (set wins over clear)
      if (data_wr) begin
        pend      <= 1'b1;
        pend_sel  <= selreg;
        pend_part <= part;
        pend_data <= cpu_din;
      end else if (commit) begin
        pend <= 1'b0;
      end

      if (commit) begin
        din   <= pend_data;
        up_ch <= commit_ch;
        if (low_ok) begin
          case (pend_sel[7:2])
            6'h28:   up_fnumlo  <= 1'b1;
            6'h29:   latch_fnum <= pend_data[5:0];
            6'h2C:   up_alg     <= 1'b1;
            6'h2D:   up_pms     <= 1'b1;
            default: ;
          endcase
        end
      end

      if (data_wr) begin
        cnt  <= CW'(BUSY_CYC);
        busy <= 1'b1;
      end else begin
        if (cen && cnt != '0) cnt <= cnt - 1'b1;
        if (cnt == '0) busy <= 1'b0;
      end

      if (cen) ch <= (ch == 3'(NUM_CH - 1)) ? 3'd0 : ch + 3'd1;
    end
  end

endmodule

// File: tb/tb_jt12_ch_wr_ctl.sv
// Directed bench for jt12_ch_wr_ctl: a 6-channel and a 3-channel instance share the bus.
module tb_jt12_ch_wr_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic [7:0] cpu_din = '0;
  logic [1:0] addr = '0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;

  logic       busy, busy3;
  logic [7:0] din, din3;
  logic [2:0] up_ch, up_ch3;
  logic [5:0] latch_fnum, latch_fnum3;
  logic       up_fnumlo, up_alg, up_pms, up_fnumlo3, up_alg3, up_pms3;
  logic [2:0] ch, ch3;

  jt12_ch_wr_ctl #(.NUM_CH(6), .BUSY_CYC(32)) u6 (
    .rst(rst), .clk(clk), .cen(cen), .cpu_din(cpu_din), .addr(addr), .cs_n(cs_n), .wr_n(wr_n),
    .busy(busy), .din(din), .up_ch(up_ch), .latch_fnum(latch_fnum),
    .up_fnumlo(up_fnumlo), .up_alg(up_alg), .up_pms(up_pms), .ch(ch));

  jt12_ch_wr_ctl #(.NUM_CH(3), .BUSY_CYC(32)) u3 (
    .rst(rst), .clk(clk), .cen(cen), .cpu_din(cpu_din), .addr(addr), .cs_n(cs_n), .wr_n(wr_n),
    .busy(busy3), .din(din3), .up_ch(up_ch3), .latch_fnum(latch_fnum3),
    .up_fnumlo(up_fnumlo3), .up_alg(up_alg3), .up_pms(up_pms3), .ch(ch3));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // cen pattern: 0 = never, 1 = every clk, 4 = every 4th clk; busy_pulses counts cen edges seen busy
  int cen_div = 0;
  int cen_cnt = 0;
  int busy_pulses = 0;
  always @(posedge clk) begin
    #1;
    cen_cnt++;
    cen = (cen_div == 1) || (cen_div == 4 && (cen_cnt % 4) == 0);
    if (cen && busy) busy_pulses++;
  end

  int n_lo = 0, n_alg = 0, n_pms = 0, n_alg3 = 0;
  logic [7:0] s_din;
  logic [2:0] s_ch, s_ch3;
  always @(negedge clk) begin
    if (up_fnumlo) begin n_lo++;  s_din = din; s_ch = up_ch; end
    if (up_alg)    begin n_alg++; s_din = din; s_ch = up_ch; end
    if (up_pms)    begin n_pms++; s_din = din; s_ch = up_ch; end
    if (up_alg3)   begin n_alg3++; s_ch3 = up_ch3; end
  end

  task automatic clr_cnt();
    n_lo = 0; n_alg = 0; n_pms = 0; n_alg3 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; cpu_din = d; cs_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cen_div = 0;
    @(negedge clk); rst = 1'b1;
    // strobe asserted during reset and held across release
    addr = 2'b01; cpu_din = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
    idle(3);
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_vec++; if (din !== 8'h00)       begin n_err++; $display("FAIL reset_din got %h want 00", din); end
    n_vec++; if (up_ch !== 3'd0)      begin n_err++; $display("FAIL reset_up_ch got %0d want 0", up_ch); end
    n_vec++; if (latch_fnum !== 6'h0) begin n_err++; $display("FAIL reset_latch got %h want 00", latch_fnum); end
    n_vec++; if (ch !== 3'd0)         begin n_err++; $display("FAIL reset_ch got %0d want 0", ch); end
    n_vec++; if ({up_fnumlo, up_alg, up_pms} !== 3'b000)
      begin n_err++; $display("FAIL reset_strobes got %b want 000", {up_fnumlo, up_alg, up_pms}); end
    rst = 1'b0;
    idle(3);
    cs_n = 1'b1; wr_n = 1'b1;
    idle(2);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_strobe_busy got %0b want 0", busy); end
  endtask

  task automatic test_fnum();
    cen_div = 1; clr_cnt();
    cpu_wr(2'b00, 8'hA4);
    cpu_wr(2'b01, 8'h2A);
    idle(3);
    n_vec++; if (latch_fnum !== 6'h2A) begin n_err++; $display("FAIL fnum_latch got %h want 2a", latch_fnum); end
    n_vec++; if (n_lo !== 0) begin n_err++; $display("FAIL fnum_latch_nostrobe got %0d want 0", n_lo); end
    cpu_wr(2'b00, 8'hA0);
    cpu_wr(2'b01, 8'h55);
    idle(3);
    n_vec++; if (n_lo !== 1)     begin n_err++; $display("FAIL fnumlo_count got %0d want 1", n_lo); end
    n_vec++; if (s_din !== 8'h55) begin n_err++; $display("FAIL fnumlo_din got %h want 55", s_din); end
    n_vec++; if (s_ch !== 3'd0)   begin n_err++; $display("FAIL fnumlo_ch got %0d want 0", s_ch); end
  endtask

  task automatic test_part();
    cen_div = 1; clr_cnt();
    cpu_wr(2'b10, 8'hB1);
    cpu_wr(2'b11, 8'h3B);
    idle(3);
    n_vec++; if (n_alg !== 1)     begin n_err++; $display("FAIL alg_count got %0d want 1", n_alg); end
    n_vec++; if (s_ch !== 3'd4)   begin n_err++; $display("FAIL alg_ch6 got %0d want 4", s_ch); end
    n_vec++; if (s_din !== 8'h3B) begin n_err++; $display("FAIL alg_din got %h want 3b", s_din); end
    n_vec++; if (n_alg3 !== 1)    begin n_err++; $display("FAIL alg3_count got %0d want 1", n_alg3); end
    n_vec++; if (s_ch3 !== 3'd1)  begin n_err++; $display("FAIL alg_ch3 got %0d want 1", s_ch3); end
  endtask

  task automatic test_back_to_back();
    cen_div = 0; idle(2); clr_cnt();
    cpu_wr(2'b00, 8'hB4);
    cpu_wr(2'b01, 8'h11);
    cpu_wr(2'b01, 8'h22);
    idle(2);
    n_vec++; if (n_pms !== 0) begin n_err++; $display("FAIL pms_before_cen got %0d want 0", n_pms); end
    cen_div = 1;
    idle(6);
    n_vec++; if (n_pms !== 1)     begin n_err++; $display("FAIL pms_count got %0d want 1", n_pms); end
    n_vec++; if (s_din !== 8'h22) begin n_err++; $display("FAIL pms_din got %h want 22", s_din); end
  endtask

  task automatic test_no_strobe();
    cen_div = 1; clr_cnt();
    cpu_wr(2'b00, 8'hA3);
    cpu_wr(2'b01, 8'hFF);
    cpu_wr(2'b00, 8'h30);
    cpu_wr(2'b01, 8'hFF);
    idle(3);
    n_vec++; if (n_lo + n_alg + n_pms !== 0)
      begin n_err++; $display("FAIL nostrobe_count got %0d want 0", n_lo + n_alg + n_pms); end
    n_vec++; if (latch_fnum !== 6'h2A) begin n_err++; $display("FAIL nostrobe_latch got %h want 2a", latch_fnum); end
    n_vec++; if (busy !== 1'b1)        begin n_err++; $display("FAIL nostrobe_busy got %0b want 1", busy); end
    n_vec++; if (din !== 8'hFF)        begin n_err++; $display("FAIL nostrobe_din got %h want ff", din); end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_timeout busy stuck at %0b", nm, busy); end
  endtask

  task automatic test_busy();
    int n = 0;
    cen_div = 0;
    do_reset();
    cen_div = 4; idle(2);
    busy_pulses = 0;
    cpu_wr(2'b01, 8'h01);
    wait_idle("busy1");
    n_vec++; if (busy_pulses !== 32) begin n_err++; $display("FAIL busy_len got %0d want 32", busy_pulses); end
    busy_pulses = 0;
    cpu_wr(2'b01, 8'h02);
    while (busy_pulses < 10 && n < 500) begin @(posedge clk); n++; end
    cpu_wr(2'b01, 8'h03);
    wait_idle("busy2");
    n_vec++; if (busy_pulses !== 42) begin n_err++; $display("FAIL busy_reload got %0d want 42", busy_pulses); end
  endtask

  task automatic test_reset_pending();
    int n = 0;
    int exp_ch = 0;
    cen_div = 0; idle(2); clr_cnt();
    cpu_wr(2'b00, 8'hB0);
    cpu_wr(2'b01, 8'h12);
    do_reset();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstpend_busy got %0b want 0", busy); end
    n_vec++; if (ch !== 3'd0)   begin n_err++; $display("FAIL rstpend_ch got %0d want 0", ch); end
    cen_div = 1;
    while (!cen && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 7; i++) begin
      n_vec++; if (ch !== 3'(exp_ch)) begin n_err++; $display("FAIL ch_seq step %0d got %0d want %0d", i, ch, exp_ch); end
      exp_ch = (exp_ch + 1) % 6;
      @(negedge clk);
    end
    idle(10);
    n_vec++; if (n_lo + n_alg + n_pms !== 0)
      begin n_err++; $display("FAIL rstpend_strobe got %0d want 0", n_lo + n_alg + n_pms); end
  endtask

  initial begin
    test_reset();
    test_fnum();
    test_part();
    test_back_to_back();
    test_no_strobe();
    test_busy();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
